// File: rtl/rx78_vram_arbiter.sv
// Single-port VRAM arbiter between the Z80 bus and video scanout. Video has priority.
// Optional CPU fairness limit when RX78_VRAM_FAIR_EN is defined.
//
// state | meaning
// IDLE  | no access in flight; arbitrate pending requests
// VID_A | video address presented to VRAM
// VID_D | video read data returned by VRAM
// CPU_A | CPU address (and write strobe) presented to VRAM
// CPU_D | CPU read data returned / access complete
module rx78_vram_arbiter #(
  parameter int ADDR_W         = 13,
  parameter int BANK_W         = 3,
  parameter int DATA_W         = 8,
  parameter int MAX_VID_STREAK = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_din,
  output logic [DATA_W-1:0]        cpu_dout,
  output logic                     cpu_done,
  output logic                     cpu_wait_n,
  input  logic                     bank_we,
  input  logic [7:0]               bank_din,
  output logic [7:0]               bank_q,
  input  logic                     vid_req,
  input  logic [ADDR_W+BANK_W-1:0] vid_addr,
  output logic [DATA_W-1:0]        vid_data,
  output logic                     vid_ack,
  output logic [ADDR_W+BANK_W-1:0] ram_addr,
  output logic                     ram_we,
  output logic [DATA_W-1:0]        ram_din,
  input  logic [DATA_W-1:0]        ram_q
);

  typedef enum logic [2:0] {IDLE, VID_A, VID_D, CPU_A, CPU_D} state_t;

  state_t state, state_nxt;
  logic   grant_vid, grant_cpu;
  logic   served;
  logic   we_lat;
  logic   cpu_pend;
  logic   fair_cpu;

  // A request still high after its own done must fall before it can be granted again.
  assign cpu_pend   = cpu_req & ~served;
  assign cpu_wait_n = reset | ~(cpu_req & ~cpu_done);

`ifdef RX78_VRAM_FAIR_EN
  localparam int SW = $clog2(MAX_VID_STREAK + 1);
  logic [SW-1:0] streak;

  assign fair_cpu = cpu_pend && (streak >= SW'(MAX_VID_STREAK));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      streak <= '0;
    else if (grant_cpu || !cpu_req)
      streak <= '0;
    else if (grant_vid && cpu_pend && (streak < SW'(MAX_VID_STREAK)))
      streak <= streak + SW'(1);
  end
`else
  assign fair_cpu = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    case (state)
      IDLE: begin
        if (vid_req && !fair_cpu) begin
          grant_vid = 1'b1;
          state_nxt = VID_A;
        end else if (cpu_pend) begin
          grant_cpu = 1'b1;
          state_nxt = CPU_A;
        end
      end
      VID_A:   state_nxt = VID_D;
      VID_D:   state_nxt = IDLE;
      CPU_A:   state_nxt = CPU_D;
      CPU_D:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address, write data and direction are captured at grant so a bank change
  // mid-access cannot disturb the in-flight cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q   <= '0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= '0;
      we_lat   <= 1'b0;
      cpu_dout <= '0;
      cpu_done <= 1'b0;
      vid_data <= '0;
      vid_ack  <= 1'b0;
      served   <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      cpu_done <= 1'b0;
      vid_ack  <= 1'b0;
      if (bank_we)
        bank_q <= bank_din;
      if (grant_vid)
        ram_addr <= vid_addr;
      if (grant_cpu) begin
        ram_addr <= {bank_q[BANK_W-1:0], cpu_addr};
        ram_we   <= cpu_we;
        ram_din  <= cpu_din;
        we_lat   <= cpu_we;
      end
      if (state == VID_D) begin
        vid_data <= ram_q;
        vid_ack  <= 1'b1;
      end
      if (state == CPU_D) begin
        if (!we_lat)
          cpu_dout <= ram_q;
        cpu_done <= 1'b1;
      end
      if (grant_cpu)
        served <= 1'b1;
      else if (!cpu_req)
        served <= 1'b0;
    end
  end

endmodule
